// File: rtl/ysyx_22050598_fwd_scoreboard_pkg.sv
// ysyx_22050598_fwd_scoreboard_pkg: shared widths, stage ordering and counter sizing
package ysyx_22050598_fwd_scoreboard_pkg;
  localparam int YSYX_XLEN = 64;
  localparam int YSYX_NREG = 32;
  localparam int YSYX_RW = $clog2(YSYX_NREG);
  localparam int YSYX_FWD_YOUNGEST = 0;
  function automatic int cnt_width(input int lim);
    return ($clog2(lim + 1) > 8) ? $clog2(lim + 1) : 8;
  endfunction
endpackage

// File: rtl/ysyx_22050598_fwd_sel.sv
// ysyx_22050598_fwd_sel: one operand's stage scan, writeback bypass and stall decision
module ysyx_22050598_fwd_sel
  import ysyx_22050598_fwd_scoreboard_pkg::*;
#(
  parameter int XLEN       = YSYX_XLEN,
  parameter int RW         = YSYX_RW,
  parameter int FWD_STAGES = 3
) (
  input  logic [RW-1:0]              i_idx,
  input  logic                       i_used,
  input  logic [XLEN-1:0]            i_rs_data,
  input  logic [FWD_STAGES-1:0]      i_fwd_en,
  input  logic [FWD_STAGES*RW-1:0]   i_fwd_rd_idx,
  input  logic [FWD_STAGES-1:0]      i_fwd_ready,
  input  logic [FWD_STAGES*XLEN-1:0] i_fwd_data,
  input  logic                       i_lw_done,
  input  logic [RW-1:0]              i_lw_rd_idx,
  input  logic [XLEN-1:0]            i_lw_data,
  input  logic                       i_pending,
  output logic [XLEN-1:0]            o_data,
  output logic                       o_stall
);
  logic            w_active, w_hit, w_rdy, w_lw_hit;
  logic [XLEN-1:0] w_sel;
  // youngest matching stage decides; older stages are shadowed
  always_comb begin
    w_hit = 1'b0;
    w_rdy = 1'b0;
    w_sel = '0;
    for (int k = YSYX_FWD_YOUNGEST; k < FWD_STAGES; k++)
      if (!w_hit && i_fwd_en[k] && i_fwd_rd_idx[k*RW +: RW] == i_idx) begin
        w_hit = 1'b1;
        w_rdy = i_fwd_ready[k];
        w_sel = i_fwd_data[k*XLEN +: XLEN];
      end
  end
  assign w_active = i_used && i_idx != '0;
  assign w_lw_hit = i_lw_done && i_lw_rd_idx == i_idx;
  assign o_stall  = w_active && (w_hit ? !w_rdy : !w_lw_hit && i_pending);
  assign o_data   = (w_active && w_hit && w_rdy) ? w_sel :
                    (w_active && !w_hit && w_lw_hit) ? i_lw_data : i_rs_data;
endmodule

// File: rtl/ysyx_22050598_fwd_scoreboard.sv
// ysyx_22050598_fwd_scoreboard: decode-stage forwarding plus long-latency scoreboard.
// Stall watchdog built only when YSYX_22050598_SB_WATCHDOG_EN is defined.
module ysyx_22050598_fwd_scoreboard
  import ysyx_22050598_fwd_scoreboard_pkg::*;
#(
  parameter int XLEN       = YSYX_XLEN,
  parameter int NREG       = YSYX_NREG,
  parameter int FWD_STAGES = 3,
  parameter int WDOG_LIMIT = 255,
  localparam int RW        = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RW-1:0]              i_id_rs1_idx,
  input  logic [RW-1:0]              i_id_rs2_idx,
  input  logic                       i_id_rs1_used,
  input  logic                       i_id_rs2_used,
  input  logic [XLEN-1:0]            i_rs1_data,
  input  logic [XLEN-1:0]            i_rs2_data,
  input  logic                       i_id_issue,
  input  logic [RW-1:0]              i_id_rd_idx,
  input  logic                       i_id_rd_long,
  input  logic [FWD_STAGES-1:0]      i_fwd_en,
  input  logic [FWD_STAGES*RW-1:0]   i_fwd_rd_idx,
  input  logic [FWD_STAGES-1:0]      i_fwd_ready,
  input  logic [FWD_STAGES*XLEN-1:0] i_fwd_data,
  input  logic                       i_lw_done,
  input  logic [RW-1:0]              i_lw_rd_idx,
  input  logic [XLEN-1:0]            i_lw_data,
  input  logic                       i_flush,
  output logic [XLEN-1:0]            o_rs1_fwd_data,
  output logic [XLEN-1:0]            o_rs2_fwd_data,
  output logic                       o_hazard_stall,
  output logic                       o_sb_busy,
  output logic                       o_wdog_err
);
  localparam logic [NREG-1:0] ONE = 1;
  logic [NREG-1:0] r_pending, w_set, w_clr;
  logic            w_stall1, w_stall2;
  ysyx_22050598_fwd_sel #(.XLEN(XLEN), .RW(RW), .FWD_STAGES(FWD_STAGES)) u_sel1 (
    .i_idx(i_id_rs1_idx), .i_used(i_id_rs1_used), .i_rs_data(i_rs1_data),
    .i_fwd_en(i_fwd_en), .i_fwd_rd_idx(i_fwd_rd_idx), .i_fwd_ready(i_fwd_ready),
    .i_fwd_data(i_fwd_data), .i_lw_done(i_lw_done), .i_lw_rd_idx(i_lw_rd_idx),
    .i_lw_data(i_lw_data), .i_pending(r_pending[i_id_rs1_idx]),
    .o_data(o_rs1_fwd_data), .o_stall(w_stall1)
  );
  ysyx_22050598_fwd_sel #(.XLEN(XLEN), .RW(RW), .FWD_STAGES(FWD_STAGES)) u_sel2 (
    .i_idx(i_id_rs2_idx), .i_used(i_id_rs2_used), .i_rs_data(i_rs2_data),
    .i_fwd_en(i_fwd_en), .i_fwd_rd_idx(i_fwd_rd_idx), .i_fwd_ready(i_fwd_ready),
    .i_fwd_data(i_fwd_data), .i_lw_done(i_lw_done), .i_lw_rd_idx(i_lw_rd_idx),
    .i_lw_data(i_lw_data), .i_pending(r_pending[i_id_rs2_idx]),
    .o_data(o_rs2_fwd_data), .o_stall(w_stall2)
  );
  assign o_hazard_stall = w_stall1 | w_stall2;
  assign o_sb_busy      = |r_pending;
  assign w_clr = i_lw_done ? ONE << i_lw_rd_idx : '0;
  assign w_set = (i_id_issue && i_id_rd_long && !o_hazard_stall && i_id_rd_idx != '0) ?
                 ONE << i_id_rd_idx : '0;
  // set is applied after clear so a newer producer survives its predecessor's writeback
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pending <= '0;
    else r_pending <= i_flush ? '0 : (r_pending & ~w_clr) | w_set;
`ifdef YSYX_22050598_SB_WATCHDOG_EN
  localparam int CW = cnt_width(WDOG_LIMIT);
  localparam logic [CW-1:0] LIM = CW'(WDOG_LIMIT);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err;
  assign w_cnt_nxt = !o_hazard_stall ? '0 : (r_cnt == LIM) ? r_cnt : r_cnt + CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | (o_hazard_stall && w_cnt_nxt == LIM);
    end
  assign o_wdog_err = r_err;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = WDOG_LIMIT == 0;
  assign o_wdog_err    = 1'b0;
`endif
endmodule

// File: doc/ysyx_22050598_fwd_scoreboard.md
# ysyx_22050598_fwd_scoreboard

Parametrised operand-forwarding and hazard unit for the decode stage, the successor to the fixed three-stage forwarder.
- Forwards from a configurable number of downstream stages.
- Tracks in-flight long-latency producers (load, mul/div, variable-latency memory) in a per-register scoreboard, so the pipeline stalls only while a needed result truly does not exist yet.
- Sits between the register file read ports and the ID/EX pipeline register.

## Interface
Parameters:
- XLEN, 64, datapath width
- NREG, 32, architectural registers; index width RW = $clog2(NREG)
- FWD_STAGES, 3, forwarding sources; stage 0 is youngest (EX)
- WDOG_LIMIT, 255, consecutive stall cycles before watchdog error

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1_idx / id_rs2_idx  in  RW  source indices
- id_rs1_used / id_rs2_used  in  1  source actually read by the instruction
- rs1_data / rs2_data  in  XLEN  register-file read data
- id_issue  in  1  ID instruction leaves ID this cycle
- id_rd_idx  in  RW  destination of the issuing instruction
- id_rd_long  in  1  destination written by a long-latency unit
- fwd_en  in  FWD_STAGES  stage holds a valid rd writer
- fwd_rd_idx  in  FWD_STAGES*RW  per-stage rd, stage k at [k*RW +: RW]
- fwd_ready  in  FWD_STAGES  stage's result is available this cycle
- fwd_data  in  FWD_STAGES*XLEN  per-stage result
- lw_done  in  1  long-latency result written back this cycle
- lw_rd_idx  in  RW  its destination
- lw_data  in  XLEN  its data
- flush  in  1  pipeline redirect; all in-flight long ops are killed
- rs1_fwd_data / rs2_fwd_data  out  XLEN  resolved operands
- hazard_stall  out  1  hold ID and bubble EX
- sb_busy  out  1  any scoreboard entry pending
- wdog_err  out  1  sticky stall-timeout flag (macro-dependent)

## Operation
Per-operand resolution (identical for rs1 and rs2):
- If the operand is unused or idx==0: data = rs_data; the operand never stalls.
- Otherwise, scan stages 0..FWD_STAGES-1. The first stage with fwd_en and a matching rd (rd!=0) decides:
  - ready=1: forward fwd_data.
  - ready=0: stall.
- If no stage matches and lw_done with lw_rd_idx==idx: forward lw_data (same-cycle writeback bypass).
- Else if pending[idx]: stall.
- Else: rs_data.

Outputs:
- hazard_stall = stall_rs1 | stall_rs2.

Scoreboard:
- pending[NREG] bits; entry 0 is never set.
- Set on id_issue & id_rd_long & ~hazard_stall & rd!=0.
- Clear on lw_done for lw_rd_idx.
- Set and clear of the same index in one cycle: set wins (a newer producer exists).
- flush clears all entries. flush and a set in the same cycle: flush wins.
- sb_busy = |pending.

## Timing
- Forwarding and stall are purely combinational from inputs and current scoreboard state; zero-cycle latency.
- Scoreboard updates are visible the cycle after the set/clear edge.
- An issue at cycle T with id_rd_long, followed by a dependent instruction at T+1 with no matching stage ready, stalls until lw_done. It resolves in the lw_done cycle via bypass.
- Reset values:
  - pending=0, watchdog counter=0, wdog_err=0.
  - Hence sb_busy=0.
  - hazard_stall depends only on fwd inputs.
- Reset asserted mid-stall clears all state immediately (asynchronous).

## Configuration
- YSYX_22050598_SB_WATCHDOG_EN defined:
  - An 8-bit+ counter increments each cycle hazard_stall=1 and resets to 0 when hazard_stall=0.
  - When the counter reaches WDOG_LIMIT, wdog_err is set and stays set until rst_n.
  - The counter saturates at WDOG_LIMIT.
- Macro undefined: no counter is built and wdog_err is tied to 0.

## Structure
- Shared defines header: register-index width, XLEN default, stage-0-youngest ordering constant.
- Sub-module ysyx_22050598_fwd_sel: one operand's stage scan, bypass and stall decision. It is instantiated twice and takes pending[idx] as an input.
- Scoreboard and watchdog live in the top module.

## Test plan
- Stage0 en, rd=5, ready=1, data=0xAA; rs1=5 used -> rs1_fwd_data=0xAA, no stall. With stage1 also rd=5 data=0xBB, output stays 0xAA (youngest wins).
- rs2=0 used, stage0 rd=0 data=0x1 -> rs2_fwd_data=rs2_data, stall=0.
- Issue long op rd=7, then rs1=7 for 4 cycles with no stage match -> stall=1 for 4 cycles. lw_done rd=7 data=0x55 -> 0x55 forwarded, stall=0; sb_busy=0 the next cycle.
- Same cycle: issue long rd=9 and lw_done rd=9 -> pending[9]=1 afterwards. Same cycle with flush -> pending=0.
- Stage0 rd=3, ready=0; rs2=3 used -> stall=1 even though pending[3]=0.
- Macro on, WDOG_LIMIT=4, hold stall 4 cycles -> wdog_err=1, which stays 1 after stall drops until rst_n is asserted low.
